// File: rtl/poly_clip_stream_if.sv
// Vertex stream bundle: one vertex per beat, valid/ready handshake, last marks polygon end.
interface poly_clip_stream_if #(
  parameter int COORD_W = 16
);
  logic                      valid;
  logic                      ready;
  logic signed [COORD_W-1:0] x;
  logic signed [COORD_W-1:0] y;
  logic                      last;

  modport master (output valid, x, y, last, input ready);
  modport slave  (input valid, x, y, last, output ready);
endinterface

// File: rtl/poly_clip_stream.sv
// Streaming Sutherland-Hodgman clipper against one screen edge.
// Vertices enter on i_vtx; the clipped polygon leaves on o_vtx through a one-entry
// hold register so that last is always flagged on the true final vertex.
module poly_clip_stream #(
  parameter int COORD_W   = 16,
  parameter int CLIP_SIDE = 0,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [COORD_W-1:0] i_clip_bound,
  poly_clip_stream_if.slave         i_vtx,
  poly_clip_stream_if.master        o_vtx,
  output logic                      o_out_empty,
  output logic [CNT_W-1:0]          o_out_count,
  output logic                      o_busy
);

  localparam int AW  = COORD_W + 1;
  localparam int PW  = 2 * COORD_W + 2;
  localparam int QW  = COORD_W + 1;
  localparam int DCW = $clog2(COORD_W + 2);
  localparam bit AXIS_Y  = (CLIP_SIDE <= 1);
  localparam bit KEEP_LE = (CLIP_SIDE == 0) || (CLIP_SIDE == 3);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(COORD_W + 1);
  localparam logic signed [COORD_W+1:0] MAXV = {3'b000, {(COORD_W-1){1'b1}}};
  localparam logic signed [COORD_W+1:0] MINV = {3'b111, {(COORD_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT_V, S_DIV, S_EMIT, S_CLOSE, S_FLUSH} state_t;

  state_t                    r_state;
  logic signed [COORD_W-1:0] r_first_x, r_first_y, r_prev_x, r_prev_y, r_cur_x, r_cur_y;
  logic signed [COORD_W-1:0] r_bound;
  logic                      r_cur_last, r_closing, r_emit_i, r_emit_cur;
  logic [DCW-1:0]            r_div_cnt;
  logic [PW-1:0]             r_rem, r_dsh;
  logic [QW-1:0]             r_quo;
  logic                      r_qneg;
  logic                      r_hold_valid;
  logic signed [COORD_W-1:0] r_hold_x, r_hold_y;
  logic                      r_out_valid, r_out_last;
  logic signed [COORD_W-1:0] r_out_x, r_out_y;
  logic                      r_empty, r_busy;
  logic [CNT_W-1:0]          r_cnt, r_count;

  function automatic logic f_inside(input logic signed [COORD_W-1:0] x,
                                    input logic signed [COORD_W-1:0] y,
                                    input logic signed [COORD_W-1:0] b);
    logic signed [COORD_W-1:0] a;
    a = AXIS_Y ? y : x;
    return KEEP_LE ? (a <= b) : (a >= b);
  endfunction

  function automatic logic signed [AW-1:0] f_sx(input logic signed [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction

  logic                      w_out_free, w_can_push, w_in_acc;
  logic                      w_pin, w_cin_in, w_cin_first;
  logic signed [COORD_W-1:0] w_p0a, w_p0o, w_p1a, w_p1o;
  logic signed [AW-1:0]      w_da, w_do, w_den;
  logic signed [PW-1:0]      w_num;
  logic [PW-1:0]             w_num_mag;
  logic [AW-1:0]             w_den_mag;
  logic                      w_ge;
  logic signed [COORD_W+1:0] w_qmag, w_q_s, w_sum;
  logic signed [COORD_W-1:0] w_io, w_ix, w_iy, w_push_x, w_push_y;
  logic                      w_push_pend, w_emit_done;
  state_t                    w_fin_state;

  assign w_out_free  = !r_out_valid || o_vtx.ready;
  assign w_can_push  = !r_hold_valid || w_out_free;
  assign i_vtx.ready = !rst && ((r_state == S_IDLE) || (r_state == S_WAIT_V)) && w_out_free;
  assign w_in_acc    = i_vtx.valid && i_vtx.ready;

  assign w_pin       = f_inside(r_prev_x, r_prev_y, r_bound);
  assign w_cin_in    = f_inside(i_vtx.x, i_vtx.y, r_bound);
  assign w_cin_first = f_inside(r_first_x, r_first_y, r_bound);

  // Edge p0=prev -> p1=cur, split into clip axis (a) and other axis (o).
  assign w_p0a = AXIS_Y ? r_prev_y : r_prev_x;
  assign w_p0o = AXIS_Y ? r_prev_x : r_prev_y;
  assign w_p1a = AXIS_Y ? r_cur_y  : r_cur_x;
  assign w_p1o = AXIS_Y ? r_cur_x  : r_cur_y;
  assign w_da  = f_sx(r_bound) - f_sx(w_p0a);
  assign w_do  = f_sx(w_p1o) - f_sx(w_p0o);
  assign w_den = f_sx(w_p1a) - f_sx(w_p0a);
  assign w_num = PW'(w_da) * PW'(w_do);
  assign w_num_mag = w_num[PW-1] ? -w_num : w_num;
  assign w_den_mag = w_den[AW-1] ? -w_den : w_den;
  assign w_ge      = (r_rem >= r_dsh);

  // Magnitude quotient is re-signed here so truncation is toward zero.
  assign w_qmag = {1'b0, r_quo};
  assign w_q_s  = r_qneg ? -w_qmag : w_qmag;
  assign w_sum  = {{2{w_p0o[COORD_W-1]}}, w_p0o} + w_q_s;
  assign w_io   = (w_sum > MAXV) ? MAXV[COORD_W-1:0] :
                  (w_sum < MINV) ? MINV[COORD_W-1:0] : w_sum[COORD_W-1:0];
  assign w_ix   = AXIS_Y ? w_io : r_bound;
  assign w_iy   = AXIS_Y ? r_bound : w_io;

  assign w_push_pend = r_emit_i || r_emit_cur;
  assign w_push_x    = r_emit_i ? w_ix : r_cur_x;
  assign w_push_y    = r_emit_i ? w_iy : r_cur_y;
  assign w_emit_done = !w_push_pend || (w_can_push && !(r_emit_i && r_emit_cur));
  assign w_fin_state = r_closing ? S_FLUSH : (r_cur_last ? S_CLOSE : S_WAIT_V);

  // Clipper FSM, divider and output hold/emit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_first_x    <= '0; r_first_y <= '0;
      r_prev_x     <= '0; r_prev_y  <= '0;
      r_cur_x      <= '0; r_cur_y   <= '0;
      r_bound      <= '0;
      r_cur_last   <= 1'b0;
      r_closing    <= 1'b0;
      r_emit_i     <= 1'b0;
      r_emit_cur   <= 1'b0;
      r_div_cnt    <= '0;
      r_rem        <= '0;
      r_dsh        <= '0;
      r_quo        <= '0;
      r_qneg       <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_x     <= '0; r_hold_y <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_x      <= '0; r_out_y  <= '0;
      r_empty      <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= '0;
      r_count      <= '0;
    end else begin
      r_empty <= 1'b0;
      if (r_out_valid && o_vtx.ready) r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_in_acc) begin
            r_first_x <= i_vtx.x; r_first_y <= i_vtx.y;
            r_prev_x  <= i_vtx.x; r_prev_y  <= i_vtx.y;
            r_bound   <= i_clip_bound;
            r_cnt     <= '0;
            r_closing <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= i_vtx.last ? S_CLOSE : S_WAIT_V;
          end
        end
        S_WAIT_V: begin
          if (w_in_acc) begin
            r_cur_x    <= i_vtx.x; r_cur_y <= i_vtx.y;
            r_cur_last <= i_vtx.last;
            r_emit_i   <= w_pin ^ w_cin_in;
            r_emit_cur <= w_cin_in;
            r_div_cnt  <= '0;
            r_state    <= (w_pin ^ w_cin_in) ? S_DIV : S_EMIT;
          end
        end
        S_CLOSE: begin
          // The closing edge reuses the normal edge path with cur = first.
          r_cur_x    <= r_first_x; r_cur_y <= r_first_y;
          r_cur_last <= 1'b0;
          r_closing  <= 1'b1;
          r_emit_i   <= w_pin ^ w_cin_first;
          r_emit_cur <= w_cin_first;
          r_div_cnt  <= '0;
          r_state    <= (w_pin ^ w_cin_first) ? S_DIV : S_EMIT;
        end
        S_DIV: begin
          if (r_div_cnt == '0) begin
            r_rem  <= w_num_mag;
            r_dsh  <= {{(PW-AW){1'b0}}, w_den_mag} << COORD_W;
            r_quo  <= '0;
            r_qneg <= w_num[PW-1] ^ w_den[AW-1];
          end else begin
            r_rem <= w_ge ? (r_rem - r_dsh) : r_rem;
            r_quo <= {r_quo[QW-2:0], w_ge};
            r_dsh <= r_dsh >> 1;
          end
          r_div_cnt <= r_div_cnt + 1'b1;
          if (r_div_cnt == DIV_LAST) r_state <= S_EMIT;
        end
        S_EMIT: begin
          if (w_push_pend && w_can_push) begin
            if (r_hold_valid) begin
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
              r_out_x     <= r_hold_x;
              r_out_y     <= r_hold_y;
            end
            r_hold_valid <= 1'b1;
            r_hold_x     <= w_push_x;
            r_hold_y     <= w_push_y;
            r_cnt        <= r_cnt + 1'b1;
            if (r_emit_i) r_emit_i <= 1'b0;
            else          r_emit_cur <= 1'b0;
          end
          if (w_emit_done) begin
            r_prev_x <= r_cur_x; r_prev_y <= r_cur_y;
            r_state  <= w_fin_state;
          end
        end
        S_FLUSH: begin
          if (!r_hold_valid) begin
            r_empty <= 1'b1;
            r_count <= r_cnt;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_out_free) begin
            r_out_valid  <= 1'b1;
            r_out_last   <= 1'b1;
            r_out_x      <= r_hold_x;
            r_out_y      <= r_hold_y;
            r_hold_valid <= 1'b0;
            r_count      <= r_cnt;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_vtx.valid = r_out_valid;
  assign o_vtx.x     = r_out_x;
  assign o_vtx.y     = r_out_y;
  assign o_vtx.last  = r_out_last;
  assign o_out_empty = r_empty;
  assign o_out_count = r_count;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_poly_clip_stream.sv
// Self-checking bench for poly_clip_stream (TOP edge) against a polygon-level clip model.
module tb_poly_clip_stream;
  localparam int W    = 16;
  localparam int SIDE = 0;

  typedef struct { int x; int y; } vtx_t;
  typedef vtx_t vq_t[$];
  typedef struct { int x; int y; bit last; } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] bound = '0;
  logic                o_empty;
  logic [7:0]          o_count;
  logic                o_busy;

  poly_clip_stream_if #(.COORD_W(W)) vin ();
  poly_clip_stream_if #(.COORD_W(W)) vout ();

  poly_clip_stream #(.COORD_W(W), .CLIP_SIDE(SIDE), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_clip_bound (bound),
    .i_vtx        (vin),
    .o_vtx        (vout),
    .o_out_empty  (o_empty),
    .o_out_count  (o_count),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  int  empties = 0;
  int  rdy_mode = 0;
  ev_t exp_q[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_inside(input vtx_t v, input int b);
    case (SIDE)
      0:       return v.y <= b;
      1:       return v.y >= b;
      2:       return v.x >= b;
      default: return v.x <= b;
    endcase
  endfunction

  function automatic vtx_t m_isect(input vtx_t p0, input vtx_t p1, input int b);
    longint a0, a1, o0, o1, q, r;
    vtx_t v;
    if (SIDE <= 1) begin a0 = p0.y; a1 = p1.y; o0 = p0.x; o1 = p1.x; end
    else           begin a0 = p0.x; a1 = p1.x; o0 = p0.y; o1 = p1.y; end
    q = ((longint'(b) - a0) * (o1 - o0)) / (a1 - a0);
    r = o0 + q;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    if (SIDE <= 1) begin v.x = int'(r); v.y = b; end
    else           begin v.x = b; v.y = int'(r); end
    return v;
  endfunction

  function automatic vq_t clip_model(input vq_t p, input int b);
    vq_t o;
    int n = p.size();
    for (int i = 0; i < n; i++) begin
      vtx_t p0 = p[i];
      vtx_t p1 = p[(i + 1) % n];
      bit in0 = m_inside(p0, b);
      bit in1 = m_inside(p1, b);
      if (in0 != in1) o.push_back(m_isect(p0, p1, b));
      if (in1) o.push_back(p1);
    end
    return o;
  endfunction

  function automatic vq_t mkpoly(input int n, input int c[12]);
    vq_t q;
    for (int i = 0; i < n; i++) begin
      vtx_t v;
      v.x = c[2*i]; v.y = c[2*i+1];
      q.push_back(v);
    end
    return q;
  endfunction

  task automatic chk_model(input string name, input vq_t got, input vq_t want);
    chk({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      chk({name, "_x"}, got[i].x, want[i].x);
      chk({name, "_y"}, got[i].y, want[i].y);
    end
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    vout.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       vout.ready = 1'b1;
        1:       vout.ready = 1'($urandom_range(0, 1));
        default: vout.ready = 1'b0;
      endcase
    end
  end

  // ---------------- output compare process ----------------
  bit                  prev_stall = 1'b0;
  logic signed [W-1:0] px, py;
  logic                pl;
  ev_t                 e_m;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", vout.valid, 1);
        chk("stall_x", vout.x, px);
        chk("stall_y", vout.y, py);
        chk("stall_last", vout.last, pl);
      end
      if (o_empty) empties++;
      if (vout.valid && vout.ready) begin
        chk("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          chk("out_x", vout.x, e_m.x);
          chk("out_y", vout.y, e_m.y);
          chk("out_last", vout.last, e_m.last);
        end
      end
      prev_stall = vout.valid && !vout.ready;
      px = vout.x; py = vout.y; pl = vout.last;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_poly(input vq_t p, input int b, input bit set_last);
    bit acc;
    bound = W'(b);
    for (int i = 0; i < p.size(); i++) begin
      vin.valid = 1'b1;
      vin.x     = W'(p[i].x);
      vin.y     = W'(p[i].y);
      vin.last  = set_last && (i == p.size() - 1);
      acc = 1'b0;
      for (int c = 0; c < 400 && !acc; c++) begin
        @(negedge clk);
        if (vin.ready) acc = 1'b1;
        @(posedge clk); #1;
      end
      chk("in_accept", acc, 1);
    end
    vin.valid = 1'b0;
    vin.last  = 1'b0;
  endtask

  task automatic run_poly(input vq_t p, input int b);
    vq_t e;
    int  e0;
    bit  done;
    ev_t ev;
    e  = clip_model(p, b);
    e0 = empties;
    for (int i = 0; i < e.size(); i++) begin
      ev.x = e[i].x; ev.y = e[i].y; ev.last = (i == e.size() - 1);
      exp_q.push_back(ev);
    end
    send_poly(p, b, 1'b1);
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk); #1;
      if (!o_busy) done = 1'b1;
    end
    chk("poly_done", done, 1);
    chk("out_count", o_count, e.size() % 256);
    chk("empty_pulses", empties - e0, (e.size() == 0) ? 1 : 0);
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) @(negedge clk);
    chk("drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c[12];
    vq_t sq, t_out, t_on, t_neg, one_in, one_out, rp, part;
    vq_t w;
    bit  seen;
    vin.valid = 1'b0; vin.x = '0; vin.y = '0; vin.last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", vout.valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_empty", o_empty, 0);
    chk("rst_count", o_count, 0);
    chk("rst_in_ready", vin.ready, 1);
    @(posedge clk); #1;

    c = '{0,0, 20,0, 20,20, 0,20, 0,0, 0,0};     sq    = mkpoly(4, c);
    c = '{0,20, 5,30, 10,20, 0,0, 0,0, 0,0};     t_out = mkpoly(3, c);
    c = '{0,0, 4,0, 0,10, 0,0, 0,0, 0,0};        t_on  = mkpoly(3, c);
    c = '{0,0, -7,30, 7,30, 0,0, 0,0, 0,0};      t_neg = mkpoly(3, c);
    c = '{3,-4, 0,0, 0,0, 0,0, 0,0, 0,0};        one_in  = mkpoly(1, c);
    c = '{3,11, 0,0, 0,0, 0,0, 0,0, 0,0};        one_out = mkpoly(1, c);

    // Hand-computed results pin the model.
    c = '{20,0, 20,10, 0,10, 0,0, 0,0, 0,0};     w = mkpoly(4, c);
    chk_model("pin_square", clip_model(sq, 10), w);
    w.delete();
    chk_model("pin_allout", clip_model(t_out, 10), w);
    c = '{4,0, 0,10, 0,0, 0,0, 0,0, 0,0};        w = mkpoly(3, c);
    chk_model("pin_onbound", clip_model(t_on, 10), w);
    c = '{-2,10, 3,10, 0,0, 0,0, 0,0, 0,0};      w = mkpoly(3, c);
    chk_model("pin_negquot", clip_model(t_neg, 10), w);

    rdy_mode = 0;
    run_poly(sq, 10);
    run_poly(t_out, 10);
    run_poly(t_on, 10);
    run_poly(t_neg, 10);
    run_poly(one_in, -4);
    run_poly(one_out, 10);

    // Downstream stall while the square is mid-stream.
    rdy_mode = 2;
    fork
      run_poly(sq, 10);
      begin
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
          @(negedge clk);
          if (vout.valid) seen = 1'b1;
        end
        chk("stall_seen", seen, 1);
        repeat (20) begin
          @(negedge clk);
          chk("stall_in_ready", vin.ready, 0);
        end
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join

    // Reset while the intersection of edge v1->v2 is being divided.
    c = '{0,0, 20,0, 20,20, 0,0, 0,0, 0,0};      part = mkpoly(3, c);
    send_poly(part, 10, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rstdiv_out_valid", vout.valid, 0);
    chk("rstdiv_busy", o_busy, 0);
    @(posedge clk); #1;
    run_poly(sq, 10);

    // Randomised polygons with random back-pressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int n;
      int b;
      logic signed [W-1:0] t;
      rp.delete();
      n = $urandom_range(1, 6);
      if (k % 2 == 0) b = int'($urandom_range(0, 20)) - 10;
      else begin t = W'($urandom); b = t; end
      for (int i = 0; i < n; i++) begin
        vtx_t v;
        if (k % 2 == 0) begin
          v.x = int'($urandom_range(0, 60)) - 30;
          v.y = int'($urandom_range(0, 60)) - 30;
        end else begin
          t = W'($urandom); v.x = t;
          t = W'($urandom); v.y = t;
        end
        rp.push_back(v);
      end
      run_poly(rp, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
